// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared state encoding, default rates and a width helper for clk_rst_seq
package clk_rst_pkg;
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, HOLD = 2'd1, RUN = 2'd2} state_t;
  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned CE0_HZ_DEF = 4_000_000;
  localparam int unsigned CE1_HZ_DEF = 7_000_000;
  localparam int unsigned ACC_W_DEF = 32;
  function automatic bit acc_fits(int unsigned w, longint unsigned v);
    return w >= 64 || (v >> w) == 0;
  endfunction
endpackage

// File: rtl/ce_frac_gen.sv
// ce_frac_gen: phase-accumulator strobe averaging CE_HZ out of CLK_HZ while en is high
module ce_frac_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CE_HZ = 4_000_000,
  parameter int unsigned ACC_W = 32
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic en,
  output logic ce
);
  localparam logic [ACC_W-1:0] STEP = ACC_W'(CE_HZ);
  localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_HZ - CE_HZ);
  logic [ACC_W-1:0] acc;
  // acc >= CLK_HZ-CE_HZ is acc+CE_HZ >= CLK_HZ without needing a wider adder
  assign ce = en && acc >= WRAP;
  always_ff @(posedge clk_sys) begin
    if (rst || !en) acc <= '0;
    else acc <= ce ? acc - WRAP : acc + STEP;
  end
endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL-lock reset sequencer with fractional clock enables (accumulators built only with CLK_RST_CE_GEN_EN)
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned CE0_HZ = CE0_HZ_DEF,
  parameter int unsigned CE1_HZ = CE1_HZ_DEF,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_rst,
  output logic sys_rst,
  output logic running,
  output logic ce_0,
  output logic ce_1
);
  localparam int unsigned HW = HOLD_CYCLES > 2 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam int unsigned CE_MAX = CE0_HZ > CE1_HZ ? CE0_HZ : CE1_HZ;
  if (CE0_HZ == 0 || CE0_HZ >= CLK_HZ || CE1_HZ == 0 || CE1_HZ >= CLK_HZ || HOLD_CYCLES < 2 ||
      !acc_fits(ACC_W, 64'(CLK_HZ) + 64'(CE_MAX))) begin : g_bad_cfg
    $error("clk_rst_seq: invalid CLK_HZ/CEx_HZ/HOLD_CYCLES/ACC_W");
  end
  state_t state, state_nx;
  logic s1, s2;
  logic [HW-1:0] hold_cnt, hold_nx;
  // lock loss beats soft_rst; soft_rst parks the FSM in HOLD with a cleared count
  always_comb begin
    state_nx = state;
    hold_nx = '0;
    if (!s2 || state == WAIT_LOCK) state_nx = s2 && !soft_rst ? HOLD : WAIT_LOCK;
    else if (soft_rst) state_nx = HOLD;
    else if (state != RUN) begin
      state_nx = hold_cnt == HOLD_LAST ? RUN : HOLD;
      hold_nx = hold_cnt == HOLD_LAST ? '0 : hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= WAIT_LOCK;
      hold_cnt <= '0;
      sys_rst <= 1'b1;
      running <= 1'b0;
    end else begin
      s1 <= pll_locked;
      s2 <= s1;
      state <= state_nx;
      hold_cnt <= hold_nx;
      sys_rst <= state_nx != RUN;
      running <= state_nx == RUN;
    end
  end
`ifdef CLK_RST_CE_GEN_EN
  ce_frac_gen #(.CLK_HZ(CLK_HZ), .CE_HZ(CE0_HZ), .ACC_W(ACC_W)) u_ce_0 (
    .clk_sys(clk_sys), .rst(rst), .en(running), .ce(ce_0)
  );
  ce_frac_gen #(.CLK_HZ(CLK_HZ), .CE_HZ(CE1_HZ), .ACC_W(ACC_W)) u_ce_1 (
    .clk_sys(clk_sys), .rst(rst), .en(running), .ce(ce_1)
  );
`else
  assign ce_0 = 1'b0;
  assign ce_1 = 1'b0;
`endif
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: random and directed stimulus against a timestamp/closed-form model of clk_rst_seq
module tb_clk_rst_seq;
  import clk_rst_pkg::*;
  localparam int H = 16;
  localparam longint CLK = CLK_HZ_DEF;
  localparam longint C0 = CE0_HZ_DEF;
  localparam longint C1 = CE1_HZ_DEF;
`ifdef CLK_RST_CE_GEN_EN
  localparam bit CE_ON = 1'b1;
`else
  localparam bit CE_ON = 1'b0;
`endif
  logic clk_sys = 1'b0, rst = 1'b1, pll_locked = 1'b0, soft_rst = 1'b0;
  logic sys_rst, running, ce_0, ce_1;
  int total = 0, bad = 0;
  clk_rst_seq #(.HOLD_CYCLES(H)) dut (
    .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .sys_rst(sys_rst), .running(running), .ce_0(ce_0), .ce_1(ce_1)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic checki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // strobe k of a run fires when k*CE/CLK crosses an integer
  function automatic bit fires(int kk, longint ce);
    return (longint'(kk) * ce) / CLK != (longint'(kk - 1) * ce) / CLK;
  endfunction
  // model: sync delay line plus the edge index at which hold counting (re)started
  bit d1 = 0, d2 = 0, s2m = 0, active = 0, run = 0, was_run = 0, chk = 0;
  int n = 0, t_start = 0, k = 0;
  always @(posedge clk_sys) begin
    if (rst) begin
      d1 = 0; d2 = 0; active = 0; run = 0; k = 0;
    end else begin
      s2m = d2;
      d2 = d1;
      d1 = pll_locked;
      if (!s2m) active = 0;
      else if (!active) begin
        if (!soft_rst) begin active = 1; t_start = n; end
      end else if (soft_rst) t_start = n;
      was_run = run;
      run = active && (n - t_start >= H);
      k = run ? (was_run ? k + 1 : 1) : 0;
    end
    n++;
    chk = 1;
  end
  always @(negedge clk_sys) if (chk) begin
    check("sys_rst", sys_rst, !run);
    check("running", running, run);
    check("ce_0", ce_0, CE_ON && run && fires(k, C0));
    check("ce_1", ce_1, CE_ON && run && fires(k, C1));
  end
  int cnt0 = 0, cnt1 = 0, last0 = 0, last1 = 0, first0 = 0, first1 = 0, gap_bad = 0;
  always @(negedge clk_sys) begin
    if (k == 0) begin last0 = 0; last1 = 0; end
    if (k == 1) begin first0 = 0; first1 = 0; end
    if (ce_0) begin
      if (k >= 1000 && k < 51000) cnt0++;
      if (first0 == 0) first0 = k;
      if (last0 != 0 && (k - last0 < 12 || k - last0 > 13)) gap_bad++;
      last0 = k;
    end
    if (ce_1) begin
      if (k >= 1000 && k < 51000) cnt1++;
      if (first1 == 0) first1 = k;
      if (last1 != 0 && (k - last1 < 7 || k - last1 > 8)) gap_bad++;
      last1 = k;
    end
  end
  // pll_locked is high and the next edge is its first high sample
  task automatic lock_check(input string nm);
    repeat (H + 2) @(negedge clk_sys);
    check({nm, "_hold"}, sys_rst, 1'b1);
    @(negedge clk_sys);
    check({nm, "_release"}, sys_rst, 1'b0);
    check({nm, "_running"}, running, 1'b1);
  endtask
  int hi;
  initial begin
    repeat (3) @(negedge clk_sys);
    check("rst_sys_rst", sys_rst, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_ce_0", ce_0, 1'b0);
    check("rst_ce_1", ce_1, 1'b0);
    rst = 0;
    repeat (4) @(negedge clk_sys);
    pll_locked = 1;
    lock_check("lock");
    repeat (51100) @(negedge clk_sys);
    checki("first_ce_0", first0, CE_ON ? 13 : 0);
    checki("first_ce_1", first1, CE_ON ? 8 : 0);
    checki("count_ce_0", cnt0, CE_ON ? 4000 : 0);
    checki("count_ce_1", cnt1, CE_ON ? 7000 : 0);
    soft_rst = 1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (i == 4) soft_rst = 0;
      if (!sys_rst) break;
      hi++;
    end
    checki("soft_rst_hold_cycles", hi, 4 + H);
    repeat (20) @(negedge clk_sys);
    checki("soft_first_ce_0", first0, CE_ON ? 13 : 0);
    checki("soft_first_ce_1", first1, CE_ON ? 8 : 0);
    repeat (30) @(negedge clk_sys);
    pll_locked = 0;
    repeat (2) @(negedge clk_sys);
    check("loss_still_run", sys_rst, 1'b0);
    @(negedge clk_sys);
    check("loss_sys_rst", sys_rst, 1'b1);
    check("loss_running", running, 1'b0);
    check("loss_ce_0", ce_0, 1'b0);
    check("loss_ce_1", ce_1, 1'b0);
    repeat (5) @(negedge clk_sys);
    pll_locked = 1;
    lock_check("relock");
    repeat (20) @(negedge clk_sys);
    checki("relock_first_ce_0", first0, CE_ON ? 13 : 0);
    pll_locked = 0;
    repeat (10) @(negedge clk_sys);
    pll_locked = 1;
    repeat (10) @(negedge clk_sys);
    pll_locked = 0;
    @(negedge clk_sys);
    pll_locked = 1;
    lock_check("glitch");
    repeat (40) @(negedge clk_sys);
    rst = 1;
    @(negedge clk_sys);
    check("mid_rst_sys_rst", sys_rst, 1'b1);
    check("mid_rst_running", running, 1'b0);
    check("mid_rst_ce_0", ce_0, 1'b0);
    check("mid_rst_ce_1", ce_1, 1'b0);
    rst = 0;
    lock_check("post_rst");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      pll_locked = $urandom_range(0, 199) != 0;
      soft_rst = $urandom_range(0, 149) == 0;
    end
    @(negedge clk_sys);
    checki("ce_spacing", gap_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
